// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle CPU: controller states, opcode/funct fields,
// ALU operation codes and datapath mux selects.
package multicycle_pkg;

    localparam int STW = 4;

    localparam logic [STW-1:0] S_INIT      = 4'd0;
    localparam logic [STW-1:0] S_FETCH     = 4'd1;
    localparam logic [STW-1:0] S_DECODE    = 4'd2;
    localparam logic [STW-1:0] S_R_EXEC    = 4'd3;
    localparam logic [STW-1:0] S_R_WB      = 4'd4;
    localparam logic [STW-1:0] S_MEM_ADDR  = 4'd5;
    localparam logic [STW-1:0] S_MEM_READ  = 4'd6;
    localparam logic [STW-1:0] S_MEM_WB    = 4'd7;
    localparam logic [STW-1:0] S_MEM_WRITE = 4'd8;
    localparam logic [STW-1:0] S_BRANCH    = 4'd9;
    localparam logic [STW-1:0] S_JUMP      = 4'd10;
    localparam logic [STW-1:0] S_ADDI_EXEC = 4'd11;
    localparam logic [STW-1:0] S_ADDI_WB   = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_funct_dec.sv
// R-type funct decoder: maps the funct field to an ALU operation and flags
// whether the funct is one the datapath implements.
module alu_funct_dec
    import multicycle_pkg::*;
#(
    parameter int FNW    = 6,
    parameter int ALUOPW = 3
) (
    input  logic [FNW-1:0]    funct,
    output logic [ALUOPW-1:0] alu_op,
    output logic              valid
);

    always_comb begin
        // NOTE: both outputs are given a value before the case, so every funct
        // assigns them and no latch is inferred.
        alu_op = ALUOPW'(ALU_ADD);
        valid  = 1'b1;
        case (funct)
            FNW'(FN_ADD): alu_op = ALUOPW'(ALU_ADD);
            FNW'(FN_SUB): alu_op = ALUOPW'(ALU_SUB);
            FNW'(FN_AND): alu_op = ALUOPW'(ALU_AND);
            FNW'(FN_OR):  alu_op = ALUOPW'(ALU_OR);
            FNW'(FN_SLT): alu_op = ALUOPW'(ALU_SLT);
            default:      valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle CPU, one instruction phase per clock.
// Define MC_MEM_WAIT_EN to stretch FETCH/MEM_READ/MEM_WRITE until mem_ready.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int OPW    = 6,
    parameter int FNW    = 6,
    parameter int ALUOPW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OPW-1:0]    opcode,
    input  logic [FNW-1:0]    funct,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              regs_clr,
    output logic              pc_ld,
    output logic              ir_ld,
    output logic              mdr_ld,
    output logic              a_ld,
    output logic              b_ld,
    output logic              aluout_ld,
    output logic              mem_read,
    output logic              mem_write,
    output logic              reg_write,
    output logic              iord,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        pc_src,
    output logic [ALUOPW-1:0] alu_op,
    output logic              illegal_op
);

    logic [STW-1:0]    state;
    logic [STW-1:0]    state_nx;
    logic [ALUOPW-1:0] fn_alu_op;
    logic              fn_valid;
    logic              mem_ok;

`ifdef MC_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok           = 1'b1;
`endif

    alu_funct_dec #(
        .FNW    (FNW),
        .ALUOPW (ALUOPW)
    ) u_funct_dec (
        .funct  (funct),
        .alu_op (fn_alu_op),
        .valid  (fn_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge values.
        if (rst) state <= S_INIT;
        else     state <= state_nx;
    end

    always_comb begin
        regs_clr   = 1'b0;
        pc_ld      = 1'b0;
        ir_ld      = 1'b0;
        mdr_ld     = 1'b0;
        a_ld       = 1'b0;
        b_ld       = 1'b0;
        aluout_ld  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        iord       = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        pc_src     = PCSRC_ALU;
        alu_op     = ALUOPW'(ALU_ADD);
        illegal_op = 1'b0;
        state_nx   = S_INIT;
        case (state)
            S_INIT: begin
                regs_clr = 1'b1;
                state_nx = S_FETCH;
            end
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_4;
                ir_ld     = mem_ok;
                pc_ld     = mem_ok;
                state_nx  = mem_ok ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                a_ld      = 1'b1;
                b_ld      = 1'b1;
                aluout_ld = 1'b1;
                alu_src_b = SRCB_IMM_SH;
                case (opcode)
                    OPW'(OP_RTYPE):            state_nx = S_R_EXEC;
                    OPW'(OP_LW), OPW'(OP_SW):  state_nx = S_MEM_ADDR;
                    OPW'(OP_BEQ):              state_nx = S_BRANCH;
                    OPW'(OP_J):                state_nx = S_JUMP;
                    OPW'(OP_ADDI):             state_nx = S_ADDI_EXEC;
                    default: begin
                        illegal_op = 1'b1;
                        state_nx   = S_FETCH;
                    end
                endcase
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                if (fn_valid) begin
                    alu_op    = fn_alu_op;
                    aluout_ld = 1'b1;
                    state_nx  = S_R_WB;
                end else begin
                    illegal_op = 1'b1;
                    state_nx   = S_FETCH;
                end
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_nx  = S_FETCH;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                aluout_ld = 1'b1;
                if (state == S_ADDI_EXEC)          state_nx = S_ADDI_WB;
                else if (opcode == OPW'(OP_LW))    state_nx = S_MEM_READ;
                else                               state_nx = S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                mdr_ld   = mem_ok;
                state_nx = mem_ok ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_nx   = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                state_nx  = mem_ok ? S_FETCH : S_MEM_WRITE;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOPW'(ALU_SUB);
                pc_src    = PCSRC_ALUOUT;
                pc_ld     = zero;
                state_nx  = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_ld    = 1'b1;
                state_nx = S_FETCH;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                state_nx  = S_FETCH;
            end
            default: state_nx = S_INIT;
        endcase
    end

endmodule
